// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: opcodes,
// ALU operation codes and the controller state type.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;

    localparam logic [6:0] F7_SUB    = 7'b0100000;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_NONE  = 4'b0000;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } ctrl_state_t;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_R_TYPE) || (op == OP_I_ALU) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational mapping of (opcode, funct7, funct3) to the ALU operation code.
// Loads/stores always add; unknown funct3 on R/I falls back to ADD.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [6:0] funct7_i,
    input  logic [2:0] funct3_i,
    output logic [3:0] alu_cc_o
);

    always_comb begin
        alu_cc_o = ALU_ADD;
        if ((opcode_i == OP_R_TYPE) || (opcode_i == OP_I_ALU)) begin
            case (funct3_i)
                // I_ALU has no SUB form, so funct7 only matters for R_TYPE.
                3'b000: if ((opcode_i == OP_R_TYPE) && (funct7_i == F7_SUB)) alu_cc_o = ALU_SUB;
                3'b111: alu_cc_o = ALU_AND;
                3'b110: alu_cc_o = ALU_OR;
                3'b100: alu_cc_o = ALU_NOR;
                3'b010: alu_cc_o = ALU_SLT;
                default: alu_cc_o = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath control bus and reports retired and illegal instructions.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem2reg,
    output logic             alu_src,
    output logic             mem_write,
    output logic             mem_read,
    output logic [3:0]       alu_cc,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [2:0]       state_dbg
);

    ctrl_state_t      state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [6:0]       f7_q, f7_d;
    logic [2:0]       f3_q, f3_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       dec_cc;
    logic             is_lw, is_sw, in_datapath;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            f7_q    <= '0;
            f3_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f7_q    <= f7_d;
            f3_q    <= f3_d;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        f7_d    = f7_q;
        f3_d    = f3_q;
        illegal = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH: if (imem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                // The IR was loaded on the FETCH exit edge, so the live fields are valid here.
                op_d = opcode;
                f7_d = funct7;
                f3_d = funct3;
                if (is_supported(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: state_d = ((op_q == OP_LW) || (op_q == OP_SW)) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .opcode_i (op_q),
        .funct7_i (f7_q),
        .funct3_i (f3_q),
        .alu_cc_o (dec_cc)
    );

    assign is_lw       = (op_q == OP_LW);
    assign is_sw       = (op_q == OP_SW);
    assign in_datapath = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);

    // Gate the Mealy fetch strobe with reset so every output is 0 while held in reset.
    assign ir_write    = reset_n && (state_q == ST_FETCH) && imem_ready;
    assign pc_write    = ir_write;
    assign alu_src     = in_datapath && ((op_q == OP_I_ALU) || is_lw || is_sw);
    assign alu_cc      = in_datapath ? dec_cc : ALU_NONE;
    assign mem_read    = (state_q == ST_MEM) && is_lw;
    assign mem_write   = (state_q == ST_MEM) && is_sw;
    assign mem2reg     = ((state_q == ST_MEM) || (state_q == ST_WB)) && is_lw;
    assign reg_write   = (state_q == ST_WB);
    assign retired_cnt = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: table of instructions with
// hand-derived expectations, a scoreboard queue, and reset/random sequences.
module tb_multicycle_controller;

    localparam int CNT_W = 32;

    logic             clk, reset_n;
    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;
    logic             imem_ready, dmem_ready;
    logic             ir_write, pc_write, reg_write, mem2reg, alu_src, mem_write, mem_read;
    logic [3:0]       alu_cc;
    logic             retire, illegal;
    logic [CNT_W-1:0] retired_cnt;
    logic [2:0]       state_dbg;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct7(funct7), .funct3(funct3),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src), .mem_write(mem_write),
        .mem_read(mem_read), .alu_cc(alu_cc), .retire(retire), .illegal(illegal),
        .retired_cnt(retired_cnt), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] BAD = 7'b1111111;
    localparam logic [6:0] F7S = 7'b0100000;

    typedef struct packed {
        logic [3:0] alu_cc;
        logic       alu_src;
        logic [7:0] cycles;
        logic [3:0] ir_cnt;
        logic [3:0] ir_cycle;
        logic [3:0] rd;
        logic [3:0] wr;
        logic [3:0] rw;
        logic [3:0] m2r;
        logic [3:0] ret;
        logic [3:0] ill;
    } res_t;

    typedef struct {
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        int         is;
        int         ds;
        res_t       exp;
    } vec_t;

    logic [$bits(res_t)-1:0] exp_q[$];
    vec_t tbl[$];
    int n_checks = 0;
    int n_pass   = 0;
    logic [CNT_W-1:0] cnt_model = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                input int is, input int ds, input logic [3:0] cc, input logic src,
                                input int cyc, input int rd, input int wr, input int rw,
                                input int m2r, input int ret, input int ill);
        vec_t v;
        v.op = op; v.f7 = f7; v.f3 = f3; v.is = is; v.ds = ds;
        v.exp.alu_cc = cc; v.exp.alu_src = src; v.exp.cycles = 8'(cyc);
        v.exp.ir_cnt = 4'd1; v.exp.ir_cycle = 4'(is);
        v.exp.rd = 4'(rd); v.exp.wr = 4'(wr); v.exp.rw = 4'(rw);
        v.exp.m2r = 4'(m2r); v.exp.ret = 4'(ret); v.exp.ill = 4'(ill);
        return v;
    endfunction

    // driver + monitor for one instruction; starts at the FETCH cycle
    task automatic run_instr(input string name, input vec_t v);
        res_t obs, exp_r;
        bit done = 0;
        obs = '0;
        exp_q.push_back(v.exp);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                opcode = v.op; funct7 = v.f7; funct3 = v.f3;
            end
            // scramble the fields after DECODE; the latched copies must win
            if (k == v.is + 2) begin
                opcode = 7'($urandom_range(0, 127));
                funct7 = 7'($urandom_range(0, 127));
                funct3 = 3'($urandom_range(0, 7));
            end
            imem_ready = (k >= v.is);
            dmem_ready = (k >= v.is + 3 + v.ds);
            #1;
            if (ir_write) begin obs.ir_cnt++; obs.ir_cycle = 4'(k); end
            if (k == v.is + 2) begin obs.alu_cc = alu_cc; obs.alu_src = alu_src; end
            if (mem_read)  obs.rd++;
            if (mem_write) obs.wr++;
            if (reg_write) obs.rw++;
            if (mem2reg)   obs.m2r++;
            if (retire)    obs.ret++;
            if (illegal)   obs.ill++;
            if (retire || illegal) begin
                done = 1;
                obs.cycles = 8'(k + 1);
            end
        end
        if (!done) check({name, " timeout"}, 32'd0, 32'd1);
        exp_r = res_t'(exp_q.pop_front());
        check({name, " alu_cc"},   32'(obs.alu_cc),   32'(exp_r.alu_cc));
        check({name, " alu_src"},  32'(obs.alu_src),  32'(exp_r.alu_src));
        check({name, " cycles"},   32'(obs.cycles),   32'(exp_r.cycles));
        check({name, " ir_cnt"},   32'(obs.ir_cnt),   32'(exp_r.ir_cnt));
        check({name, " ir_cycle"}, 32'(obs.ir_cycle), 32'(exp_r.ir_cycle));
        check({name, " mem_read"}, 32'(obs.rd),       32'(exp_r.rd));
        check({name, " mem_write"},32'(obs.wr),       32'(exp_r.wr));
        check({name, " reg_write"},32'(obs.rw),       32'(exp_r.rw));
        check({name, " mem2reg"},  32'(obs.m2r),      32'(exp_r.m2r));
        check({name, " retire"},   32'(obs.ret),      32'(exp_r.ret));
        check({name, " illegal"},  32'(obs.ill),      32'(exp_r.ill));
        cnt_model = cnt_model + CNT_W'(exp_r.ret);
        @(posedge clk);
        #1;
        check({name, " retired_cnt"}, retired_cnt, cnt_model);
        check({name, " back_to_fetch"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        opcode = '0; funct7 = '0; funct3 = '0;
        #2;
        check("reset state", 32'(state_dbg), 32'd0);
        check("reset cnt", retired_cnt, 32'd0);
        check("reset outputs", {28'd0, ir_write, reg_write, mem_write, mem_read},  32'd0);
        check("reset alu", {27'd0, alu_cc, alu_src}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        //          op   f7    f3      is ds cc       src cyc rd wr rw m2r ret ill
        tbl.push_back(mk(R,   7'd0, 3'b000, 0, 0, 4'b0010, 0, 4, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(R,   F7S,  3'b000, 0, 0, 4'b0110, 0, 4, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(I,   F7S,  3'b000, 0, 0, 4'b0010, 1, 4, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(LW,  7'd0, 3'b010, 0, 3, 4'b0010, 1, 8, 4, 0, 1, 5, 1, 0));
        tbl.push_back(mk(SW,  7'd0, 3'b010, 0, 0, 4'b0010, 1, 4, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(BAD, 7'd0, 3'b000, 0, 0, 4'b0000, 0, 2, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(R,   7'd0, 3'b111, 2, 0, 4'b0000, 0, 6, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(R,   7'd0, 3'b110, 0, 0, 4'b0001, 0, 4, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(I,   7'd0, 3'b100, 1, 0, 4'b1100, 1, 5, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(R,   7'd0, 3'b010, 0, 0, 4'b0111, 0, 4, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(R,   7'd0, 3'b001, 0, 0, 4'b0010, 0, 4, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(R,   F7S,  3'b111, 0, 0, 4'b0000, 0, 4, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(SW,  F7S,  3'b000, 1, 2, 4'b0010, 1, 7, 0, 3, 0, 0, 1, 0));
        tbl.push_back(mk(LW,  7'd0, 3'b111, 0, 0, 4'b0010, 1, 5, 1, 0, 1, 2, 1, 0));
        tbl.push_back(mk(BAD, F7S,  3'b101, 1, 0, 4'b0000, 0, 3, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(I,   F7S,  3'b101, 0, 0, 4'b0010, 1, 4, 0, 0, 1, 0, 1, 0));

        foreach (tbl[i]) run_instr($sformatf("v%0d", i), tbl[i]);

        for (int r = 0; r < 4; r++) begin
            int is = $urandom_range(0, 3);
            run_instr($sformatf("rnd%0d", r), mk(R, 7'd0, 3'b000, is, 0, 4'b0010, 0, 4 + is, 0, 0, 1, 0, 1, 0));
        end

        // reset dropped while a store is stalled in MEM
        opcode = SW; funct7 = '0; funct3 = 3'b010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            imem_ready = 1'b1;
            dmem_ready = 1'b0;
        end
        #1;
        check("sw stall mem_write", 32'(mem_write), 32'd1);
        check("sw stall state", 32'(state_dbg), 32'd3);
        reset_n = 1'b0;
        cnt_model = '0;
        #1;
        check("rst mem_write", 32'(mem_write), 32'd0);
        check("rst outputs", {27'd0, retire, reg_write, mem_read, ir_write, alu_src}, 32'd0);
        check("rst alu_cc", 32'(alu_cc), 32'd0);
        check("rst cnt", retired_cnt, 32'd0);
        @(negedge clk);
        imem_ready = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst state", 32'(state_dbg), 32'd0);
        check("post rst mem_write", 32'(mem_write), 32'd0);
        run_instr("post_rst", mk(R, F7S, 3'b000, 0, 0, 4'b0110, 0, 4, 0, 0, 1, 0, 1, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control unit that drives the control inputs of `data_path` (`reg_write`, `mem2reg`, `alu_src`, `mem_write`, `mem_read`, `alu_cc`) from the `opcode`/`funct7`/`funct3` fields that `data_path` exports. It sequences each instruction through fetch, decode, execute, memory and writeback states, with ready handshakes to instruction and data memory. It also reports retired and illegal instructions. It is the producer of the control bus that the datapath consumes, and replaces the combinational control used on the datapath bench.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instruction opcode from `data_path`.
- `funct7`  in  7  instruction funct7 from `data_path`.
- `funct3`  in  3  instruction funct3 from `data_path`.
- `imem_ready`  in  1  instruction memory has a valid word this cycle.
- `dmem_ready`  in  1  data memory has completed the access this cycle.
- `ir_write`  out  1  load the instruction register.
- `pc_write`  out  1  advance the PC (PC+4).
- `reg_write`  out  1  register file write enable.
- `mem2reg`  out  1  writeback source is memory.
- `alu_src`  out  1  ALU operand B is the immediate.
- `mem_write`  out  1  data memory write strobe.
- `mem_read`  out  1  data memory read strobe.
- `alu_cc`  out  4  ALU operation code.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `illegal`  out  1  one-cycle pulse when an opcode is unsupported.
- `retired_cnt`  out  CNT_W  count of retired instructions.

## Operation
- Supported opcodes:
  - R_TYPE 0110011
  - I_ALU 0010011
  - LW 0000011
  - SW 0100011
- States and transitions:
  - FETCH: go to DECODE when `imem_ready`=1, otherwise stay in FETCH.
  - DECODE: latch `opcode`, `funct7` and `funct3` into internal registers. Supported opcode goes to EXEC. Unsupported opcode pulses `illegal` and goes to FETCH.
  - EXEC: R/I go to WB; LW/SW go to MEM.
  - MEM: hold until `dmem_ready`=1. Then LW goes to WB; SW pulses `retire` and goes to FETCH.
  - WB: pulse `retire` and go to FETCH.
- `alu_cc` is decoded from the latched fields:
  - funct3 000: ADD 0010, or SUB 0110 when R_TYPE and funct7=0100000. I_ALU ignores funct7, so it is always ADD.
  - funct3 111: AND 0000.
  - funct3 110: OR 0001.
  - funct3 100: NOR 1100.
  - funct3 010: SLT 0111.
  - LW/SW: always ADD 0010, regardless of funct3.
  - Any other funct3 on R/I: 0010; `illegal` is not raised.
- Outputs are Moore, derived only from the state register and the latched fields:
  - `ir_write` and `pc_write`: 1 in FETCH while `imem_ready`=1. This is the only Mealy term.
  - `alu_src`: 1 in EXEC, MEM and WB for I_ALU, LW and SW.
  - `alu_cc`: valid in EXEC, MEM and WB. It holds the decoded code in those states and is 0000 elsewhere.
  - `mem_read`: 1 throughout MEM for LW.
  - `mem_write`: 1 throughout MEM for SW.
  - `mem2reg`: 1 in MEM and WB for LW.
  - `reg_write`: 1 only in WB.
- `retired_cnt` increments by 1 on every `retire` pulse and wraps modulo 2^CNT_W.

## Timing
- Reset (`reset_n`=0, asynchronous): state is FETCH, latched fields are 0, `retired_cnt`=0, and every output is 0. This holds mid-instruction: a pending MEM access is abandoned with no write strobe after the reset edge.
- Minimum latency with ready signals tied high:
  - R/I: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 5 cycles.
  - SW: 4 cycles.
- Each cycle of `imem_ready`=0 or `dmem_ready`=0 adds one cycle. While stalled in MEM, all outputs hold stable.
- `retire` and `illegal` are never high in the same cycle. `illegal` occurs in DECODE; `retire` occurs in WB or MEM.
- Changes to `opcode`/`funct` after DECODE have no effect until the next DECODE.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - opcode constants;
  - `alu_cc` constants (ADD, SUB, AND, OR, NOR, SLT);
  - the state enum type `ctrl_state_t`.
- One sub-module, `alu_decoder`: combinational mapping from (opcode, funct7, funct3) to `alu_cc`, reusable by single-cycle variants.

## Test plan
- R-type ADD (funct7=0, funct3=000), ready high:
  - `ir_write` in cycle 0;
  - `alu_cc`=0010 with `alu_src`=0 in cycle 2;
  - `reg_write`=1 and `retire`=1 in cycle 3;
  - `retired_cnt`=1.
- R-type SUB (funct7=0100000):
  - `alu_cc`=0110.
- I_ALU (funct7=0100000, funct3=000):
  - `alu_cc`=0010 with `alu_src`=1.
- LW with `dmem_ready` low for 3 cycles:
  - `mem_read`=1 for 4 cycles;
  - `mem2reg`=1 and `reg_write`=1 in WB;
  - 8 cycles total.
- SW, ready high:
  - `mem_write`=1 for exactly 1 cycle in MEM;
  - `reg_write` stays 0;
  - `retire` in the same cycle as `mem_write`;
  - 4 cycles total.
- Opcode 1111111:
  - `illegal` pulses in DECODE;
  - no write strobes;
  - return to FETCH;
  - `retired_cnt` unchanged.
- `reset_n` dropped during a SW MEM stall:
  - `mem_write` goes to 0 immediately;
  - state is FETCH after release;
  - `retired_cnt`=0.
